// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and default sizing for the data-memory arbiter.
package dmem_arbiter_pkg;
   typedef enum logic {ARB_M = 1'b0, ARB_D = 1'b1} arbStateT;
   typedef enum logic {OWN_M = 1'b0, OWN_D = 1'b1} ownerT;

   localparam int DEF_MAX_WAIT  = 8;
   localparam int DEF_MAX_BURST = 16;
   localparam int DEF_CNT_W     = 5;
endpackage

// File: rtl/dmem_arb_resp.sv
// One-cycle read-return register: captures memory read data for a granted read
// and raises exactly one requester's rvalid on the following cycle.
module dmem_arb_resp #(
   parameter int NUM_REQ = 2,
   parameter int OWN_W   = 1,
   parameter int DATA_W  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               capture,
   input  logic [OWN_W-1:0]   owner,
   input  logic [DATA_W-1:0]  rdIn,
   output logic [NUM_REQ-1:0] rvalid,
   output logic [DATA_W-1:0]  rdata
);
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (capture) begin
         rdata <= rdIn;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : gRvalid
         logic validQ;
         always_ff @(posedge clk) begin
            if (rst) begin
               validQ <= 1'b0;
            end else begin
               validQ <= capture && (owner == OWN_W'(gi));
            end
         end
         assign rvalid[gi] = validQ;
      end
   endgenerate
endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester DMEM arbiter: pipeline has priority, DMA bursts are bounded and
// starvation-limited. Define DMEM_ARB_STATS_EN to add the stat_stall_cnt output.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int MAX_WAIT  = DEF_MAX_WAIT,
   parameter int MAX_BURST = DEF_MAX_BURST,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m_req,
   input  logic        m_we,
   input  logic [3:0]  m_wmask,
   input  logic [31:0] m_addr,
   input  logic [31:0] m_wdata,
   output logic        m_stall,
   output logic        m_rvalid,
   output logic [31:0] m_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_wmask,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic        d_last,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        mem_we,
   output logic [3:0]  mem_wmask,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [31:0] stat_stall_cnt
`endif
);
   localparam logic [CNT_W-1:0] WAIT_LIM   = CNT_W'(MAX_WAIT - 1);
   localparam logic [CNT_W-1:0] BURST_LIM  = CNT_W'(MAX_BURST - 1);
   localparam bit               MULTI_BEAT = (MAX_BURST > 1);

   arbStateT         state;
   logic [CNT_W-1:0] waitCnt;
   logic [CNT_W-1:0] burstCnt;
   logic             forceD;
   logic             mGnt;
   logic             dGnt;
   logic             capture;
   ownerT            owner;
   logic [1:0]       rvalidVec;
   logic [31:0]      rdataQ;

   // Grants are combinational so the winner's access hits memory this cycle.
   always_comb begin
      forceD = 1'b0;
      mGnt   = 1'b0;
      dGnt   = 1'b0;
      if (!rst) begin
         if (state == ARB_M) begin
            forceD = d_req && (waitCnt == WAIT_LIM);
            mGnt   = m_req && !forceD;
            dGnt   = d_req && !mGnt;
         end else begin
            dGnt   = d_req;
         end
      end
   end

   assign m_stall = m_req && !rst && !mGnt;
   assign d_gnt   = dGnt;

   assign mem_addr  = dGnt ? d_addr  : m_addr;
   assign mem_wd    = dGnt ? d_wdata : m_wdata;
   assign mem_wmask = dGnt ? d_wmask : m_wmask;
   assign mem_we    = dGnt ? d_we    : (mGnt && m_we);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ARB_M;
         waitCnt  <= '0;
         burstCnt <= '0;
      end else begin
         case (state)
            ARB_M: begin
               if (dGnt) begin
                  waitCnt <= '0;
                  if (!d_last && MULTI_BEAT) begin
                     state    <= ARB_D;
                     burstCnt <= CNT_W'(1);
                  end
               end else if (mGnt && d_req) begin
                  waitCnt <= waitCnt + 1'b1;
               end
            end
            ARB_D: begin
               // A dropped request, last beat or exhausted burst budget hands memory back.
               if (!d_req || d_last || (burstCnt == BURST_LIM)) begin
                  state    <= ARB_M;
                  burstCnt <= '0;
               end else begin
                  burstCnt <= burstCnt + 1'b1;
               end
            end
            default: state <= ARB_M;
         endcase
      end
   end

   assign capture = (mGnt && !m_we) || (dGnt && !d_we);
   assign owner   = dGnt ? OWN_D : OWN_M;

   dmem_arb_resp #(
      .NUM_REQ (2),
      .OWN_W   (1),
      .DATA_W  (32)
   ) uResp (
      .clk     (clk),
      .rst     (rst),
      .capture (capture),
      .owner   (owner),
      .rdIn    (mem_rd),
      .rvalid  (rvalidVec),
      .rdata   (rdataQ)
   );

   assign m_rvalid = rvalidVec[OWN_M];
   assign d_rvalid = rvalidVec[OWN_D];
   assign m_rdata  = rdataQ;
   assign d_rdata  = rdataQ;

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_stall_cnt <= '0;
      end else if (m_stall && (stat_stall_cnt != 32'hFFFF_FFFF)) begin
         stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
   end
`endif
endmodule
